// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the IF fetch path and the MEM load/store path.
// Sequences req/ack bus cycles with timeout, returns read data and drives the pipeline stall vector.
module mem_bus_arbiter #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   // fetch path
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_inst,
   output logic        if_rdy,
   // load/store path
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_wdata,
   input  logic [3:0]  mem_sel,
   output logic [31:0] mem_rdata,
   output logic        mem_rdy,
   // external bus
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_sel,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack,
   output logic        bus_err,
   // pipeline control
   output logic [5:0]  stall
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_IF_ACC,
      ST_MEM_ACC
   } state_t;

   localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [5:0]       LP_STALL_MEM = 6'b011111;
   localparam logic [5:0]       LP_STALL_IF  = 6'b010001;

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_bus_req;
   logic              r_bus_we;
   logic [31:0]       r_bus_addr;
   logic [31:0]       r_bus_wdata;
   logic [3:0]        r_bus_sel;
   logic              r_bus_err;
   logic [31:0]       r_if_inst;
   logic              r_if_rdy;
   logic [31:0]       r_mem_rdata;
   logic              r_mem_rdy;

   logic              w_grant_ok;
   logic              w_timeout;
   logic [5:0]        w_stall;

   // A requester still shows its req during its own rdy cycle; granting then would replay it.
   assign w_grant_ok = !r_if_rdy && !r_mem_rdy;
   assign w_timeout  = (r_cnt == LP_CNT_LAST);

   // NOTE: all state uses non-blocking assignments so every register samples pre-edge values;
   // the pulse outputs are defaulted low first, making each set a single-cycle pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_wdata <= '0;
         r_bus_sel   <= '0;
         r_bus_err   <= 1'b0;
         r_if_inst   <= '0;
         r_if_rdy    <= 1'b0;
         r_mem_rdata <= '0;
         r_mem_rdy   <= 1'b0;
      end else begin
         r_if_rdy  <= 1'b0;
         r_mem_rdy <= 1'b0;
         r_bus_err <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (w_grant_ok && mem_req) begin
                  r_state     <= ST_MEM_ACC;
                  r_bus_req   <= 1'b1;
                  r_bus_we    <= mem_we;
                  r_bus_addr  <= mem_addr;
                  r_bus_wdata <= mem_wdata;
                  r_bus_sel   <= mem_sel;
               end else if (w_grant_ok && if_req) begin
                  r_state     <= ST_IF_ACC;
                  r_bus_req   <= 1'b1;
                  r_bus_we    <= 1'b0;
                  r_bus_addr  <= if_addr;
                  r_bus_wdata <= '0;
                  r_bus_sel   <= 4'b1111;
               end
            end

            ST_IF_ACC, ST_MEM_ACC: begin
               if (bus_ack || w_timeout) begin
                  r_state   <= ST_IDLE;
                  r_cnt     <= '0;
                  r_bus_req <= 1'b0;
                  r_bus_err <= !bus_ack;
                  if (r_state == ST_IF_ACC) begin
                     r_if_rdy  <= 1'b1;
                     r_if_inst <= bus_ack ? bus_rdata : 32'h0;
                  end else begin
                     r_mem_rdy <= 1'b1;
                     // An acked store keeps the previous load data; a timeout always zeroes it.
                     if (!bus_ack)
                        r_mem_rdata <= 32'h0;
                     else if (!r_bus_we)
                        r_mem_rdata <= bus_rdata;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            default: begin
               r_state   <= ST_IDLE;
               r_cnt     <= '0;
               r_bus_req <= 1'b0;
            end
         endcase
      end
   end

   // NOTE: combinational block assigns its output a default first so no latch is inferred.
   always_comb begin
      w_stall = 6'b000000;
      if (!rst)
         w_stall = 6'b000000;
      else if (mem_req && !r_mem_rdy)
         w_stall = LP_STALL_MEM;
      else if (if_req && !r_if_rdy)
         w_stall = LP_STALL_IF;
   end

   assign bus_req   = r_bus_req;
   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_wdata = r_bus_wdata;
   assign bus_sel   = r_bus_sel;
   assign bus_err   = r_bus_err;
   assign if_inst   = r_if_inst;
   assign if_rdy    = r_if_rdy;
   assign mem_rdata = r_mem_rdata;
   assign mem_rdy   = r_mem_rdy;
   assign stall     = w_stall;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomized self-checking bench for mem_bus_arbiter; expectations come from a
// transaction-timeline model (grant, ack latency, timeout) computed per case.
module tb_mem_bus_arbiter;

   localparam int T = 16;

   logic        clk;
   logic        rst;
   logic        if_req;
   logic [31:0] if_addr;
   logic [31:0] if_inst;
   logic        if_rdy;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_sel;
   logic [31:0] mem_rdata;
   logic        mem_rdy;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_sel;
   logic [31:0] bus_rdata;
   logic        bus_ack;
   logic        bus_err;
   logic [5:0]  stall;

   int n_checks = 0;
   int n_fail   = 0;

   // reference copies of the data outputs
   logic [31:0] m_if_inst   = 32'h0;
   logic [31:0] m_mem_rdata = 32'h0;

   mem_bus_arbiter #(.TIMEOUT(T), .CNT_W(5)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_inst   (if_inst),
      .if_rdy    (if_rdy),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_sel   (mem_sel),
      .mem_rdata (mem_rdata),
      .mem_rdy   (mem_rdy),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_sel   (bus_sel),
      .bus_rdata (bus_rdata),
      .bus_ack   (bus_ack),
      .bus_err   (bus_err),
      .stall     (stall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int lat_eff(input int l);
      return (l < T - 1) ? l : T - 1;
   endfunction

   function automatic logic [5:0] exp_stall(input bit mreq, input bit mrdy, input bit ireq, input bit irdy);
      if (mreq && !mrdy) return 6'b011111;
      if (ireq && !irdy) return 6'b010001;
      return 6'b000000;
   endfunction

   // Cycles with no request: bus must stay quiet, stray acks have no effect.
   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk) #1;
         if_req    = 1'b0;
         mem_req   = 1'b0;
         if_addr   = $urandom;
         mem_addr  = $urandom;
         mem_wdata = $urandom;
         bus_rdata = $urandom;
         bus_ack   = ($urandom_range(0, 1) == 0);
         @(negedge clk);
         check("idle_bus_req", 32'(bus_req), 32'd0);
         check("idle_rdy",     32'({if_rdy, mem_rdy, bus_err}), 32'd0);
         check("idle_stall",   32'(stall), 32'd0);
         check("idle_if_inst", if_inst, m_if_inst);
         check("idle_mem_rd",  mem_rdata, m_mem_rdata);
      end
      bus_ack = 1'b0;
   endtask

   // One case: optional MEM and/or IF request raised together in cycle 0.
   // Lat = cycles from bus_req rise to ack; lat >= T means no ack (timeout).
   task automatic run_case(input bit do_if, input bit do_mem, input bit we_i,
                           input logic [31:0] if_a, input logic [31:0] mem_a,
                           input logic [31:0] mem_wd, input logic [3:0] sel_i,
                           input int lat_if, input int lat_mem, input bit drop,
                           input logic [31:0] rd_if, input logic [31:0] rd_mem);
      int  g_m, d_m, a_m, g_i, d_i, a_i, s_i, m_end, i_end, last;
      bit  err_m, err_i, in_m, in_i, mrdy, irdy;
      g_m = -1; d_m = -1; a_m = -1; g_i = -1; d_i = -1; a_i = -1;
      err_m = 1'b0; err_i = 1'b0;
      if (do_mem) begin
         g_m   = 1;
         d_m   = 2 + lat_eff(lat_mem);
         a_m   = (lat_mem < T) ? g_m + lat_mem : -1;
         err_m = (lat_mem >= T);
      end
      if (do_if) begin
         s_i   = do_mem ? d_m + 1 : 0;
         g_i   = s_i + 1;
         d_i   = s_i + 2 + lat_eff(lat_if);
         a_i   = (lat_if < T) ? g_i + lat_if : -1;
         err_i = (lat_if >= T);
      end
      m_end = (drop && !do_if)  ? 0 : d_m;
      i_end = (drop && !do_mem) ? 0 : d_i;
      last  = (d_m > d_i) ? d_m : d_i;

      for (int c = 0; c <= last; c++) begin
         @(posedge clk) #1;
         mem_req = do_mem && (c <= m_end);
         if_req  = do_if  && (c <= i_end);
         // requester fields are only meaningful until the grant edge
         if (do_mem && c < g_m) begin
            mem_we = we_i; mem_addr = mem_a; mem_wdata = mem_wd; mem_sel = sel_i;
         end else begin
            mem_we = 1'($urandom); mem_addr = $urandom; mem_wdata = $urandom; mem_sel = 4'($urandom);
         end
         if (do_if && c < g_i) if_addr = if_a;
         else                  if_addr = $urandom;

         in_m = (c >= g_m) && (c < d_m);
         in_i = (c >= g_i) && (c < d_i);
         if (c == a_m && do_mem) begin
            bus_ack = 1'b1; bus_rdata = rd_mem;
         end else if (c == a_i && do_if) begin
            bus_ack = 1'b1; bus_rdata = rd_if;
         end else begin
            bus_ack   = !(in_m || in_i) && ($urandom_range(0, 3) == 0);
            bus_rdata = $urandom;
         end

         @(negedge clk);
         mrdy = do_mem && (c == d_m);
         irdy = do_if  && (c == d_i);
         check("bus_req", 32'(bus_req), 32'(in_m || in_i));
         if (in_m) begin
            check("mem_bus_addr", bus_addr,          mem_a);
            check("mem_bus_we",   32'(bus_we),       32'(we_i));
            check("mem_bus_sel",  32'(bus_sel),      32'(sel_i));
            check("mem_bus_wd",   bus_wdata,         mem_wd);
         end
         if (in_i) begin
            check("if_bus_addr",  bus_addr,          if_a);
            check("if_bus_we",    32'(bus_we),       32'd0);
            check("if_bus_sel",   32'(bus_sel),      32'hF);
         end
         check("mem_rdy", 32'(mem_rdy), 32'(mrdy));
         check("if_rdy",  32'(if_rdy),  32'(irdy));
         check("bus_err", 32'(bus_err), 32'((mrdy && err_m) || (irdy && err_i)));
         check("stall",   32'(stall),   32'(exp_stall(mem_req, mrdy, if_req, irdy)));
         if (mrdy) begin
            if (err_m)      m_mem_rdata = 32'h0;
            else if (!we_i) m_mem_rdata = rd_mem;
         end
         if (irdy) m_if_inst = err_i ? 32'h0 : rd_if;
         check("mem_rdata", mem_rdata, m_mem_rdata);
         check("if_inst",   if_inst,   m_if_inst);
      end
      bus_ack = 1'b0;
   endtask

   initial begin
      rst = 1'b0;
      if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
      if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0; mem_sel = 4'h0;
      bus_rdata = 32'h0; bus_ack = 1'b1;

      // reset state, with requests and ack active
      repeat (3) @(negedge clk);
      check("rst_bus_req", 32'(bus_req), 32'd0);
      check("rst_stall",   32'(stall),   32'd0);
      check("rst_pulses",  32'({if_rdy, mem_rdy, bus_err}), 32'd0);
      check("rst_data",    if_inst | mem_rdata, 32'h0);
      if_req = 1'b0; mem_req = 1'b0; bus_ack = 1'b0;
      rst = 1'b1;
      idle(2);

      // directed: fetch, collision, store, timeout, zero-wait back-to-back fetches
      run_case(1, 0, 0, 32'h100, 32'h0,   32'h0,        4'hF, 3,   0, 0, 32'h3C01ABCD, 32'h0);
      idle(1);
      run_case(1, 1, 0, 32'h104, 32'h200, 32'h0,        4'hF, 1,   2, 0, 32'h11112222, 32'hCAFEF00D);
      idle(1);
      run_case(0, 1, 1, 32'h0,   32'h300, 32'hDEADBEEF, 4'b0011, 0, 1, 0, 32'h0, 32'h55AA55AA);
      idle(1);
      run_case(1, 0, 0, 32'h108, 32'h0,   32'h0,        4'hF, T,   0, 0, 32'h12345678, 32'h0);
      idle(1);
      for (int k = 0; k < 4; k++)
         run_case(1, 0, 0, 32'h200 + 32'(4 * k), 32'h0, 32'h0, 4'hF, 0, 0, 0, 32'hA0000000 + 32'(k), 32'h0);
      // ack in the last cycle before the timeout would fire
      run_case(0, 1, 0, 32'h0, 32'h400, 32'h0, 4'hF, 0, T - 1, 0, 32'h0, 32'h0BADC0DE);
      idle(1);

      // randomized cases
      for (int k = 0; k < 70; k++) begin
         int  sel_kind, li, lm;
         bit  di, dm, dr;
         sel_kind = int'($urandom_range(0, 2));
         di = (sel_kind != 1);
         dm = (sel_kind != 0);
         li = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T - 2, T + 2)) : int'($urandom_range(0, 5));
         lm = ($urandom_range(0, 7) == 0) ? int'($urandom_range(T - 2, T + 2)) : int'($urandom_range(0, 5));
         dr = !(di && dm) && ($urandom_range(0, 4) == 0);
         run_case(di, dm, 1'($urandom), $urandom, $urandom, $urandom, 4'($urandom),
                  li, lm, dr, $urandom, $urandom);
         idle(int'($urandom_range(0, 2)));
      end

      // async reset in the middle of a load that is never acked
      @(posedge clk) #1;
      mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h500; mem_sel = 4'hF; bus_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("pre_rst_bus_req", 32'(bus_req), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_bus_req", 32'(bus_req), 32'd0);
      check("mid_rst_stall",   32'(stall),   32'd0);
      check("mid_rst_pulses",  32'({if_rdy, mem_rdy, bus_err}), 32'd0);
      check("mid_rst_data",    if_inst | mem_rdata, 32'h0);
      m_if_inst = 32'h0; m_mem_rdata = 32'h0;
      bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
      @(negedge clk);
      mem_req = 1'b0;
      bus_ack = 1'b0;
      rst = 1'b1;
      idle(6);
      run_case(1, 1, 0, 32'h600, 32'h700, 32'h0, 4'hF, 2, 0, 0, 32'h600D600D, 32'h7E57DA7A);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // hard time limit so the run always ends
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
